serial_add_ctrl: RTL

Bit-serial multi-bit adder controller. It loads two WIDTH-bit operands on a start handshake and streams them LSB-first through one single-bit full adder, one bit per clock, registering the carry between bits. It assembles the sum, carry-out and signed overflow, then presents them with a one-cycle done pulse. It sits directly around the single-bit full-adder cell: it drives that cell's a/b/cin inputs and consumes its sum/cout each cycle.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/adder_exercise.sv | 18 +
 rtl/serial_add_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/adder_exercise.sv
// Single-bit full adder cell; the only arithmetic element in the serial adder.
module adder_exercise (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half_sum;

  always_comb begin
    half_sum = a ^ b;
    sum      = half_sum ^ cin;
    cout     = (a & b) | (cin & half_sum);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: streams operands LSB-first through one full-adder cell
// and reports sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  adder_exercise u_fa (
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == LastBit);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from registered state, so no input-to-output path exists.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  busy = 1'b0;
      StShift: busy = 1'b1;
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

  // Datapath next-state
  always_comb begin
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    result_d    = result_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_a_d      = op_a;
          sh_b_d      = op_b;
          carry_d     = cin_init;
          cnt_d       = '0;
          result_d    = '0;
          carry_out_d = 1'b0;
          overflow_d  = 1'b0;
        end
      end
      StShift: begin
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        sh_a_d   = sh_a_q >> 1;
        sh_b_d   = sh_b_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // On the MSB the registered carry is the carry into the sign bit.
        if (last_bit) begin
          overflow_d  = carry_q ^ fa_cout;
          carry_out_d = fa_cout;
        end
      end
      StDone: begin
        sh_a_d = sh_a_q;
      end
      default: begin
        sh_a_d = sh_a_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
